aes_input_loader: RTL and testbench
===================================

Name: aes_input_loader

Overview:
Upstream staging block for the AES-128 datapath. It accepts key and plaintext as 32-bit words over a valid/ready stream and assembles them into 128-bit shadow registers. Once a block is complete, it presents the 128-bit state and key, and issues a one-cycle start pulse to the AES core. Its registered state output also drives the state-monitor (TSC) input; it holds that value stable until the core reports completion.

Parameters:
WORD_W, 32, input word width
DATA_W, 128, state/key width; DATA_W must be a multiple of WORD_W
NWORDS, DATA_W/WORD_W (4), words per key or plaintext block; derived, not overridable

Ports:
clk  in  1  system clock; all logic on the rising edge
rst  in  1  reset, synchronous and active-high
in_valid  in  1  upstream word valid
in_ready  out  1  loader can accept a word
in_data  in  WORD_W  key/plaintext word, most-significant word first
key_keep  in  1  sampled in IDLE: 1 = reuse the current key and skip key load
core_done  in  1  one-cycle pulse from the AES core: block finished
start  out  1  one-cycle pulse: state/key valid, core begins
state  out  DATA_W  plaintext block presented to the core and the monitor
key  out  DATA_W  key presented to the core
busy  out  1  high from ISSUE through WAIT_CORE
blk_cnt  out  32  count of issued blocks; wraps at 2^32-1 to 0

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - FSM goes to IDLE; word counter = 0.
  - Shadows, state, key, blk_cnt = 0; start = busy = in_ready = 0.
  - Reset wins over every other event, including mid-load and WAIT_CORE; a partially loaded block is discarded.
- Handshake:
  - A word is accepted on an edge where in_valid & in_ready = 1.
  - in_valid without in_ready consumes nothing.
  - in_data is ignored while in_ready = 0.
- FSM states: IDLE, LOAD_KEY, LOAD_PT, ISSUE, WAIT_CORE.
  - IDLE: in_ready = 0. Next edge goes to LOAD_PT if key_keep = 1, else LOAD_KEY. Word counter cleared.
  - LOAD_KEY: in_ready = 1. Each accepted word shifts into key_shadow: shadow <= {shadow[DATA_W-WORD_W-1:0], in_data}. On the NWORDS-th accepted word, the counter clears and the FSM goes to LOAD_PT.
  - LOAD_PT: same shifting into pt_shadow. On the NWORDS-th accepted word, the FSM goes to ISSUE.
  - ISSUE (exactly one cycle):
    - start = 1, busy = 1, in_ready = 0.
    - state and key outputs are registered from the shadows on the edge entering ISSUE, so they are valid in the same cycle start is high.
    - blk_cnt increments on the edge leaving ISSUE.
    - Next state is WAIT_CORE.
  - WAIT_CORE: busy = 1, in_ready = 0, state/key held. On core_done = 1, the FSM goes to IDLE.
- core_done outside WAIT_CORE (including during the ISSUE cycle) is ignored.
- key_keep after reset: the key register is 0, and that zero key is used.
- Latency:
  - The first edge after a reset-release edge goes IDLE->LOAD.
  - start is high in the cycle after the edge that accepts the last plaintext word.
  - Minimum cycles from IDLE to start: 1 + 8 without key_keep; 1 + 4 with key_keep.
- state and key outputs never change while busy = 1.

Decomposition:
- Package aes_loader_pkg:
  - FSM enum loader_state_t {IDLE, LOAD_KEY, LOAD_PT, ISSUE, WAIT_CORE}
  - WORD_W / DATA_W / NWORDS localparams
  - BLK_CNT_W = 32
- One sub-module, aes_word_shreg: parameterised WORD_W/DATA_W shift-in register with a load enable and a synchronous clear. It is instantiated twice, for key_shadow and pt_shadow.
- The FSM, counters and output registers stay in the top module.

Test Plan:
1. Reset, then key 2b7e1516,28aed2a6,abf71588,09cf4f3c and plaintext 3243f6a8,885a308d,313198a2,e0370734, with in_valid held high. Required: start pulses once, in_ready is low from that cycle, key = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c, state = 128'h3243f6a8_885a308d_313198a2_e0370734, blk_cnt = 1 after the start cycle.
2. After case 1, core_done pulses, then key_keep = 1 and plaintext 00112233,44556677,8899aabb,ccddeeff. Required: only 4 words are accepted, key is unchanged, state = 128'h00112233_44556677_8899aabb_ccddeeff, blk_cnt = 2.
3. in_valid toggled randomly during load, plus core_done pulsed during ISSUE and during LOAD_PT. Required: exactly 8 words are consumed, core_done in those states is ignored, and busy stays high until a core_done in WAIT_CORE.
4. rst asserted after the 6th accepted word. Required: on the next edge all outputs = 0 and the FSM is in IDLE; a fresh full load then produces the correct block, with no residue of the old words.
5. Preload blk_cnt to 32'hFFFFFFFF via force, then issue one block. Required: blk_cnt = 0.
6. in_valid = 1 during WAIT_CORE with in_data changing. Required: in_ready = 0 and state/key stay bit-stable until core_done.

Source files
------------

// File: rtl/aes_loader_pkg.sv
// Shared types and sizes for the AES-128 input loader.
`timescale 1ns/1ps
package aes_loader_pkg;
   localparam int WORD_W    = 32;
   localparam int DATA_W    = 128;
   localparam int NWORDS    = DATA_W / WORD_W;
   localparam int BLK_CNT_W = 32;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_KEY,
      LOAD_PT,
      ISSUE,
      WAIT_CORE
   } loader_state_t;
endpackage

// File: rtl/aes_word_shreg.sv
// Word-wide shift-in register; nxt_o is the value after the next shift.
`timescale 1ns/1ps
module aes_word_shreg #(
   parameter int WORD_W = 32,
   parameter int DATA_W = 128
) (
   input  logic              clk,
   input  logic              clr_i,
   input  logic              en_i,
   input  logic [WORD_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o,
   output logic [DATA_W-1:0] nxt_o
);
   logic [DATA_W-1:0] sh_q;
   logic [DATA_W-1:0] sh_d;

   assign nxt_o = {sh_q[DATA_W-WORD_W-1:0], d_i};
   assign sh_d  = en_i ? nxt_o : sh_q;
   assign q_o   = sh_q;

   always_ff @(posedge clk) begin
      if (clr_i) sh_q <= '0;
      else       sh_q <= sh_d;
   end
endmodule

// File: rtl/aes_input_loader.sv
// Collects key and plaintext words, then presents a 128-bit block to the AES core.
`timescale 1ns/1ps
module aes_input_loader #(
   parameter int WORD_W = aes_loader_pkg::WORD_W,
   parameter int DATA_W = aes_loader_pkg::DATA_W
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   output logic                                 in_ready,
   input  logic [WORD_W-1:0]                    in_data,
   input  logic                                 key_keep,
   input  logic                                 core_done,
   output logic                                 start,
   output logic [DATA_W-1:0]                    state,
   output logic [DATA_W-1:0]                    key,
   output logic                                 busy,
   output logic [aes_loader_pkg::BLK_CNT_W-1:0] blk_cnt
);
   import aes_loader_pkg::*;

   localparam int NW = DATA_W / WORD_W;
   localparam int CW = (NW > 1) ? $clog2(NW) : 1;

   loader_state_t          fsm_q, fsm_d;
   logic [CW-1:0]          wcnt_q, wcnt_d;
   logic [DATA_W-1:0]      st_q, st_d;
   logic [DATA_W-1:0]      key_q, key_d;
   logic [BLK_CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
   logic                   ld_key, ld_pt, issue_ld;
   logic                   last;
   logic [DATA_W-1:0]      key_sh, key_nxt;
   logic [DATA_W-1:0]      pt_sh, pt_nxt;

   aes_word_shreg #(.WORD_W(WORD_W), .DATA_W(DATA_W)) u_key_sh (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (ld_key),
      .d_i   (in_data),
      .q_o   (key_sh),
      .nxt_o (key_nxt)
   );

   aes_word_shreg #(.WORD_W(WORD_W), .DATA_W(DATA_W)) u_pt_sh (
      .clk   (clk),
      .clr_i (rst),
      .en_i  (ld_pt),
      .d_i   (in_data),
      .q_o   (pt_sh),
      .nxt_o (pt_nxt)
   );

   assign last = (wcnt_q == CW'(NW - 1));

   always_comb begin
      fsm_d    = fsm_q;
      wcnt_d   = wcnt_q;
      ld_key   = 1'b0;
      ld_pt    = 1'b0;
      issue_ld = 1'b0;
      in_ready = 1'b0;
      start    = 1'b0;
      busy     = 1'b0;
      unique case (fsm_q)
         IDLE: begin
            wcnt_d = '0;
            fsm_d  = key_keep ? LOAD_PT : LOAD_KEY;
         end
         LOAD_KEY: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ld_key = 1'b1;
               if (last) begin
                  wcnt_d = '0;
                  fsm_d  = LOAD_PT;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         LOAD_PT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               ld_pt = 1'b1;
               if (last) begin
                  wcnt_d   = '0;
                  issue_ld = 1'b1;
                  fsm_d    = ISSUE;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         ISSUE: begin
            start = 1'b1;
            busy  = 1'b1;
            fsm_d = WAIT_CORE;
         end
         WAIT_CORE: begin
            busy = 1'b1;
            if (core_done) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   // The last plaintext word bypasses the shadow so the block is whole in ISSUE.
   assign st_d      = issue_ld ? pt_nxt : st_q;
   assign key_d     = issue_ld ? key_sh : key_q;
   assign blk_cnt_d = blk_cnt_q + BLK_CNT_W'(start);

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q     <= IDLE;
         wcnt_q    <= '0;
         st_q      <= '0;
         key_q     <= '0;
         blk_cnt_q <= '0;
      end else begin
         fsm_q     <= fsm_d;
         wcnt_q    <= wcnt_d;
         st_q      <= st_d;
         key_q     <= key_d;
         blk_cnt_q <= blk_cnt_d;
      end
   end

   assign state   = st_q;
   assign key     = key_q;
   assign blk_cnt = blk_cnt_q;
endmodule

// File: tb/tb_aes_input_loader.sv
// Table-driven, scoreboarded bench for the AES input loader.
`timescale 1ns/1ps
module tb_aes_input_loader;
   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [31:0]  in_data;
   logic         key_keep;
   logic         core_done;
   logic         start;
   logic [127:0] state;
   logic [127:0] key;
   logic         busy;
   logic [31:0]  blk_cnt;

   aes_input_loader dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .key_keep  (key_keep),
      .core_done (core_done),
      .start     (start),
      .state     (state),
      .key       (key),
      .busy      (busy),
      .blk_cnt   (blk_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         kk;
      int           n;
      logic [255:0] words;
      logic         gaps;
      logic         cd_load;
      logic         cd_issue;
      logic [127:0] exp_st;
      logic [127:0] exp_key;
   } vec_t;

   typedef struct {
      logic [127:0] st;
      logic [127:0] k;
      logic [31:0]  cnt;
   } exp_t;

   vec_t   tbl [6];
   exp_t   sbq [$];
   int     checks = 0;
   int     errors = 0;
   int     acc_cnt = 0;
   logic [31:0]  exp_cnt = 0;
   logic         busy_p = 1'b0;
   logic [127:0] st_p, key_p;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (in_valid && in_ready) acc_cnt++;
      if (busy_p && !rst) begin
         checks++;
         if (state !== st_p || key !== key_p) begin
            errors++;
            $display("FAIL hold act=%h/%h exp=%h/%h", state, key, st_p, key_p);
         end
      end
      busy_p = busy;
      st_p   = state;
      key_p  = key;
      if (start) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_start", 1, 0);
         end else begin
            e = sbq.pop_front();
            chk("sb_state", state, e.st);
            chk("sb_key", key, e.k);
            chk("sb_cnt_at_start", blk_cnt, e.cnt);
            chk("sb_ready_at_start", in_ready, 0);
         end
      end
   end

   task automatic send_words(input logic [255:0] w, input int n,
                             input logic gaps, input logic cd_load);
      int   i = 0;
      int   budget = 0;
      logic acc;
      while (i < n && budget < 200) begin
         in_data   = w[255 - 32*i -: 32];
         in_valid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         core_done = (cd_load && i == n - 2 && in_ready) ? 1'b1 : 1'b0;
         acc = in_valid && in_ready;
         step();
         if (acc) i++;
         budget++;
      end
      core_done = 1'b0;
      in_valid  = 1'b0;
      if (i < n) chk("send_timeout", i, n);
   endtask

   task automatic run_block(input vec_t v);
      exp_t e;
      int   a0;
      key_keep = v.kk;
      e.st  = v.exp_st;
      e.k   = v.exp_key;
      e.cnt = exp_cnt;
      sbq.push_back(e);
      a0 = acc_cnt;
      send_words(v.words, v.n, v.gaps, v.cd_load);
      chk("start_latency", start, 1);
      chk("ready_in_issue", in_ready, 0);
      core_done = v.cd_issue;
      in_valid  = 1'b1;
      in_data   = $urandom;
      step();
      core_done = 1'b0;
      exp_cnt   = exp_cnt + 1;
      chk("start_one_cycle", start, 0);
      chk("busy_wait", busy, 1);
      chk("blk_cnt", blk_cnt, exp_cnt);
      chk("words_accepted", acc_cnt - a0, v.n);
      repeat (3) begin
         in_valid = 1'b1;
         in_data  = $urandom;
         step();
         chk("busy_hold", busy, 1);
         chk("ready_wait", in_ready, 0);
      end
      core_done = 1'b1;
      step();
      core_done = 1'b0;
      in_valid  = 1'b0;
      chk("busy_done", busy, 0);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_start"}, start, 0);
      chk({nm, "_busy"}, busy, 0);
      chk({nm, "_ready"}, in_ready, 0);
      chk({nm, "_state"}, state, 0);
      chk({nm, "_key"}, key, 0);
      chk({nm, "_cnt"}, blk_cnt, 0);
   endtask

   initial begin
      tbl[0] = '{1'b0, 8,
         {32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c,
          32'h3243f6a8, 32'h885a308d, 32'h313198a2, 32'he0370734},
         1'b0, 1'b0, 1'b0,
         128'h3243f6a8_885a308d_313198a2_e0370734,
         128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};
      tbl[1] = '{1'b1, 4,
         {32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff, 128'h0},
         1'b0, 1'b0, 1'b0,
         128'h00112233_44556677_8899aabb_ccddeeff,
         128'h2b7e1516_28aed2a6_abf71588_09cf4f3c};
      tbl[2] = '{1'b0, 8,
         {32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
          32'hdeadbeef, 32'h01234567, 32'h89abcdef, 32'ha5a5c3c3},
         1'b1, 1'b1, 1'b1,
         128'hdeadbeef_01234567_89abcdef_a5a5c3c3,
         128'h00010203_04050607_08090a0b_0c0d0e0f};
      tbl[3] = '{1'b0, 8,
         {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
          32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888},
         1'b0, 1'b0, 1'b0,
         128'h55555555_66666666_77777777_88888888,
         128'h11111111_22222222_33333333_44444444};
      tbl[4] = '{1'b1, 4,
         {32'h0badc0de, 32'hfeedface, 32'h13579bdf, 32'h2468ace0, 128'h0},
         1'b0, 1'b0, 1'b0,
         128'h0badc0de_feedface_13579bdf_2468ace0, 128'h0};
      tbl[5] = '{1'b1, 4,
         {32'ha1b2c3d4, 32'he5f60718, 32'h293a4b5c, 32'h6d7e8f90, 128'h0},
         1'b0, 1'b0, 1'b0,
         128'ha1b2c3d4_e5f60718_293a4b5c_6d7e8f90, 128'h0};

      rst = 1'b1; in_valid = 1'b0; in_data = '0;
      key_keep = 1'b0; core_done = 1'b0;
      step();
      step();
      chk_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 3; i++) run_block(tbl[i]);

      key_keep = 1'b0;
      send_words(tbl[2].words, 6, 1'b0, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_cnt = 0;
      chk_zero("midload_rst");
      run_block(tbl[3]);

      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_cnt = 0;
      run_block(tbl[4]);

      key_keep = 1'b1;
      force dut.blk_cnt_q = 32'hFFFFFFFF;
      step();
      release dut.blk_cnt_q;
      exp_cnt = 32'hFFFFFFFF;
      run_block(tbl[5]);
      chk("wrap_cnt", blk_cnt, 0);

      chk("sb_empty", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
